// File: rtl/axil_data_mem_pkg.sv
// Shared types and constants for the AXI4-Lite data memory: response codes,
// channel FSM state encodings and the latched write-beat payload.
package axil_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [AXIL_DATA_W-1:0] data;
        logic [AXIL_STRB_W-1:0] strb;
    } wbeat_t;

endpackage

// File: rtl/axil_data_mem_if.sv
// AXI4-Lite bus bundle between the CPU wrapper master and the data memory slave.
interface axil_data_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_data_mem_dp_ram_be.sv
// Word-organised RAM: one byte-enabled write port, one synchronous read port,
// read-before-write on a same-address collision. Contents are never reset.
module dp_ram_be #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Non-blocking read of mem gives the pre-write word when addresses collide.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axil_data_mem.sv
// AXI4-Lite slave data memory with independent write and read channel FSMs.
// Optional feature macro: AXIL_DECERR_EN (out-of-range accesses answer DECERR).
module axil_data_mem
    import axil_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic            clk,
    input  logic            rstn,
    axil_data_mem_if.slave  s_axil
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    wr_state_e         wr_state_q, wr_state_n;
    rd_state_e         rd_state_q, rd_state_n;
    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic              rdata_en_q;
    logic [ADDR_W-1:0] aw_addr_q;
    wbeat_t            w_beat_q;

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_W-1:0] wr_addr, aw_offs, ar_offs;
    wbeat_t            w_beat;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              aw_in_range, ar_in_range, wr_err, rd_err;
    logic [DATA_W-1:0] ram_rdata;

    function automatic logic [ADDR_W-1:0] offset(input logic [ADDR_W-1:0] a);
        return ADDR_W'(a - BASE_ADDR);
    endfunction

    assign aw_hs = s_axil.awvalid && awready_q;
    assign w_hs  = s_axil.wvalid  && wready_q;
    assign ar_hs = s_axil.arvalid && arready_q;

    // Commit uses the latched half of the transaction when it arrived earlier.
    assign wr_addr = (wr_state_q == W_HAVE_AW) ? aw_addr_q : s_axil.awaddr;
    assign w_beat  = (wr_state_q == W_HAVE_W)  ? w_beat_q
                                               : wbeat_t'({s_axil.wdata, s_axil.wstrb});

    assign aw_offs     = offset(wr_addr);
    assign ar_offs     = offset(s_axil.araddr);
    assign wr_idx      = aw_offs[IDX_W+1:2];
    assign rd_idx      = ar_offs[IDX_W+1:2];
    assign aw_in_range = (aw_offs[ADDR_W-1:IDX_W+2] == '0);
    assign ar_in_range = (ar_offs[ADDR_W-1:IDX_W+2] == '0);

`ifdef AXIL_DECERR_EN
    assign wr_err = !aw_in_range;
    assign rd_err = !ar_in_range;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{aw_offs[1:0], ar_offs[1:0], aw_in_range, ar_in_range};

    // Write channel next-state and commit decode.
    always_comb begin
        wr_state_n = wr_state_q;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit  = 1'b1;
                    wr_state_n = W_RESP;
                end else if (aw_hs) begin
                    wr_state_n = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_n = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    wr_commit  = 1'b1;
                    wr_state_n = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    wr_commit  = 1'b1;
                    wr_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // Read channel next-state decode.
    always_comb begin
        rd_state_n = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs)         rd_state_n = R_DATA;
            R_DATA:  if (s_axil.rready) rd_state_n = R_IDLE;
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_addr_q  <= '0;
            w_beat_q   <= '0;
        end else begin
            wr_state_q <= wr_state_n;
            awready_q  <= (wr_state_n == W_IDLE) || (wr_state_n == W_HAVE_W);
            wready_q   <= (wr_state_n == W_IDLE) || (wr_state_n == W_HAVE_AW);
            bvalid_q   <= (wr_state_n == W_RESP);
            if (wr_commit) bresp_q   <= wr_err ? RESP_DECERR : RESP_OKAY;
            if (aw_hs)     aw_addr_q <= s_axil.awaddr;
            if (w_hs)      w_beat_q  <= w_beat;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_en_q <= 1'b0;
        end else begin
            rd_state_q <= rd_state_n;
            arready_q  <= (rd_state_n == R_IDLE);
            rvalid_q   <= (rd_state_n == R_DATA);
            if (ar_hs) begin
                rresp_q    <= rd_err ? RESP_DECERR : RESP_OKAY;
                rdata_en_q <= !rd_err;
            end
        end
    end

    dp_ram_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_commit && !wr_err),
        .be    (w_beat.strb),
        .waddr (wr_idx),
        .wdata (w_beat.data),
        .re    (ar_hs),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    // RAM read register has no reset; gate it so rdata is 0 after reset and on DECERR.
    assign s_axil.rdata   = rdata_en_q ? ram_rdata : '0;

endmodule

// File: tb/tb_axil_data_mem.sv
// Directed self-checking bench for axil_data_mem (default and AXIL_DECERR_EN builds).
module tb_axil_data_mem;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    axil_data_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_data_mem #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_axil (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input string tag);
        int n;
        n = 0;
        while (!bus.bvalid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_blat"}, n, 0);
        check({tag, "_bvalid"}, 32'(bus.bvalid), 1);
        check({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp,
                              input string tag);
        bit aw_done, w_done, aw_t, w_t;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata  = data; bus.wstrb   = strb; bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_t = bus.awvalid && bus.awready;
            w_t  = bus.wvalid && bus.wready;
            tick();
            if (aw_t) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_t)  begin w_done  = 1; bus.wvalid  = 1'b0; end
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!(aw_done && w_done)) check({tag, "_hs_timeout"}, 0, 1);
        wait_b(exp_resp, tag);
    endtask

    task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input string tag);
        bit done, t;
        int n;
        done = 0; n = 0;
        bus.araddr = addr; bus.arvalid = 1'b1;
        while (!done && n < 20) begin
            t = bus.arready;
            tick();
            n++;
            if (t) done = 1;
        end
        bus.arvalid = 1'b0;
        if (!done) check({tag, "_ar_timeout"}, 0, 1);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 1);
        check({tag, "_rdata"}, bus.rdata, exp_data);
        check({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0;  bus.araddr  = '0; bus.arvalid = 0; bus.rready = 0;

        // Reset state: readies high, valids low, responses and rdata zero.
        repeat (3) tick();
        check("rst_ctrl", 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 32'h1C);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_resp", 32'({bus.bresp, bus.rresp}), 32'h0);
        rstn = 1'b1;
        tick();

        // 1: AW+W together, then readback with 1-cycle latency.
        axil_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "t1_wr");
        axil_read (32'h10, 32'hDEADBEEF, 2'b00, "t1_rd");

        // 2: W first, AW three cycles later, low-half strobes.
        bus.wdata = 32'h0000CAFE; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("t2_have_w", 32'({bus.awready, bus.wready, bus.bvalid}), 32'h4);
        tick(); tick();
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        wait_b(2'b00, "t2_wr");
        axil_read(32'h10, 32'hDEADCAFE, 2'b00, "t2_rd");

        // Zero strobes change nothing; single-lane write; addr[1:0] ignored.
        axil_write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00, "t2_s0");
        axil_read (32'h10, 32'hDEADCAFE, 2'b00, "t2_s0_rd");
        axil_write(32'h12, 32'h00770000, 4'h4, 2'b00, "t2_s4");
        axil_read (32'h13, 32'hDE77CAFE, 2'b00, "t2_s4_rd");

        // 3: bready low for 5 cycles holds the response and blocks AW/W.
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", 32'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 32'h10);
            tick();
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("t3_release", 32'({bus.bvalid, bus.awready, bus.wready}), 32'h3);

        // 4: rready low for 4 cycles holds rdata and blocks AR.
        bus.araddr = 32'h20; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_rdata_hold", bus.rdata, 32'h12345678);
            check("t4_ctrl_hold", 32'({bus.rvalid, bus.arready}), 32'h2);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("t4_release", 32'({bus.rvalid, bus.arready}), 32'h1);

        // 4b: write commit and read of the same word on one edge return old data.
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        bus.wdata = 32'hAAAA5555; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h20; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("t4_rbw_rdata", bus.rdata, 32'h12345678);
        check("t4_rbw_valids", 32'({bus.bvalid, bus.rvalid}), 32'h3);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        axil_read(32'h20, 32'hAAAA5555, 2'b00, "t4_new");

        // 5: reset with a write in W_HAVE_AW and a read in R_DATA.
        axil_write(32'h30, 32'h11112222, 4'hF, 2'b00, "t5_pre");
        bus.awaddr = 32'h30; bus.awvalid = 1'b1;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        check("t5_pending", 32'({bus.awready, bus.wready, bus.rvalid}), 32'h3);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_ctrl", 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 32'h1C);
        check("t5_rst_rdata", bus.rdata, 32'h0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        // A lone W after reset must wait for a new AW rather than commit to 0x30.
        bus.wdata = 32'h99999999; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick();
        check("t5_no_bvalid", 32'(bus.bvalid), 0);
        bus.awaddr = 32'h34; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        wait_b(2'b00, "t5_wr");
        axil_read(32'h30, 32'h11112222, 2'b00, "t5_rd30");
        axil_read(32'h34, 32'h99999999, 2'b00, "t5_rd34");
        axil_read(32'h10, 32'hDE77CAFE, 2'b00, "t5_rd10");

        // 6: last valid word and one past the end of the map.
        axil_write(32'hFFC, 32'h5A5A5A5A, 4'hF, 2'b00, "t6_last");
        axil_read (32'hFFC, 32'h5A5A5A5A, 2'b00, "t6_last_rd");
        axil_write(32'h0, 32'h0BADF00D, 4'hF, 2'b00, "t6_w0");
`ifdef AXIL_DECERR_EN
        axil_write(32'h1000, 32'hFFFFFFFF, 4'hF, 2'b11, "t6_oor_wr");
        axil_read (32'h1000, 32'h0, 2'b11, "t6_oor_rd");
        axil_read (32'h0, 32'h0BADF00D, 2'b00, "t6_w0_rd");
`else
        axil_write(32'h1000, 32'h13572468, 4'hF, 2'b00, "t6_alias_wr");
        axil_read (32'h0, 32'h13572468, 2'b00, "t6_alias_rd0");
        axil_read (32'h1000, 32'h13572468, 2'b00, "t6_alias_rd");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
